// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write arbiter.
//   ADDR_W     : register index width
//   NREGS      : number of architectural registers
//   ZERO_REG   : hard-wired zero register (XZR), never written
//   wr_state_t : arbiter sequencing states
// ---------------------------------------------------------------------------
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int NREGS    = 2 ** ADDR_W;
    localparam int ZERO_REG = NREGS - 1;

    typedef enum logic {CLEAR, RUN} wr_state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Requester bus and register-file write port of the write arbiter.
//   wr_stall   : register file busy
//   req_valid  : per-requester pending write
//   req_addr   : per-requester target register (packed, ADDR_W each)
//   req_data   : per-requester write data (packed, DATA_W each)
//   req_ready  : one-hot grant back to the requesters
//   wr_en      : registered decoder enable
//   wr_addr    : registered decoder select
//   wr_data    : registered write data
//   clear_done : zeroing sweep finished
// Modports: slave = arbiter side, master = requester / register-file side.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic                     wr_stall;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clear_done;

    modport slave (
        input  wr_stall, req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, clear_done
    );

    modport master (
        output wr_stall, req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, clear_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first set bit of req found
// searching circularly upward from ptr.
//   req   : request vector
//   ptr   : highest-priority index, must be < NREQ
//   grant : one-hot grant (all zero when no request)
//   any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic             any
);
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ and k < NREQ, so one subtraction is enough to wrap
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            idx = sum[PTR_W-1:0];
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register-file write port among NREQ requesters round-robin.
// After every reset it first zeroes registers 0..NREGS-2 (XZR is skipped).
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester handshake and registered write port (slave side)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | zeroing sweep, one register per unstalled cycle, no grants
//   RUN   | round-robin service of requesters, one write per cycle
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);
    import regfile_pkg::wr_state_t;
    import regfile_pkg::CLEAR;
    import regfile_pkg::RUN;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ZREG  = (1 << ADDR_W) - 1;

    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [PTR_W-1:0]  ptr_q;

    logic [NREQ-1:0]   grant;
    logic              grant_any;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;
    logic              last_clear;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .any   (grant_any)
    );

    always_comb begin
        gidx     = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx     = PTR_W'(i);
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        ptr_nxt = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == RUN && !bus.wr_stall) begin
            bus.req_ready = grant;
        end
    end

    assign xfer       = grant_any && (state_q == RUN) && !bus.wr_stall;
    assign last_clear = (cnt_q == ADDR_W'(ZREG - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (!bus.wr_stall && last_clear) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            ptr_q          <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.clear_done <= 1'b0;
        end else begin
            bus.wr_en      <= 1'b0;
            bus.clear_done <= (state_d == RUN);
            if (state_q == CLEAR) begin
                if (!bus.wr_stall) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= cnt_q;
                    bus.wr_data <= '0;
                    cnt_q       <= cnt_q + 1'b1;
                end
            end else if (xfer) begin
                // XZR writes are consumed but never reach the decoder
                bus.wr_en   <= (sel_addr != ADDR_W'(ZREG));
                bus.wr_addr <= sel_addr;
                bus.wr_data <= sel_data;
                ptr_q       <= ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int ZREG   = 31;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [NREQ-1:0]   va;
    logic [ADDR_W-1:0] ra [NREQ];
    logic [DATA_W-1:0] rd [NREQ];
    logic              st;

    logic              m_run;
    logic [ADDR_W-1:0] m_cnt;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_ptr;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.wr_stall  = st;
        bus.req_valid = va;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W] = ra[i];
            bus.req_data[i*DATA_W +: DATA_W] = rd[i];
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = '0;
        m_addr = '0;
        m_data = '0;
        m_ptr  = 0;
        sb.delete();
    endtask

    function automatic int exp_grant();
        int g;
        g = -1;
        if (m_run && !st) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && va[i]) g = i;
            end
        end
        return g;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en"},      64'(bus.wr_en),      '0);
        chk({tag, " wr_addr"},    64'(bus.wr_addr),    '0);
        chk({tag, " wr_data"},    bus.wr_data,         '0);
        chk({tag, " req_ready"},  64'(bus.req_ready),  '0);
        chk({tag, " clear_done"}, 64'(bus.clear_done), '0);
    endtask

    // One clock: drive, check the grant, push the expected write, then pop
    // and compare against the registered outputs after the edge.
    task automatic cycle(input string tag);
        logic [NREQ-1:0] er;
        exp_t e;
        int g;
        apply();
        #1;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'(er));
        if (!m_run) begin
            if (!st) begin
                e.en   = 1'b1;
                m_addr = m_cnt;
                m_data = '0;
                if (m_cnt == ADDR_W'(ZREG - 1)) m_run = 1'b1;
                m_cnt++;
            end else begin
                e.en = 1'b0;
            end
        end else if (g >= 0) begin
            m_addr = ra[g];
            m_data = rd[g];
            e.en   = (ra[g] != ADDR_W'(ZREG));
            m_ptr  = (g + 1) % NREQ;
        end else begin
            e.en = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        e.done = m_run;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " wr_en"},      64'(bus.wr_en),      64'(e.en));
        chk({tag, " wr_addr"},    64'(bus.wr_addr),    64'(e.addr));
        chk({tag, " wr_data"},    bus.wr_data,         e.data);
        chk({tag, " clear_done"}, 64'(bus.clear_done), 64'(e.done));
    endtask

    initial begin
        reset_n = 1'b0;
        va = '0;
        st = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // clean zeroing sweep, then two idle RUN cycles
        for (int c = 0; c < 33; c++) cycle("sweep");
        chk("sweep done", 64'(bus.clear_done), 64'(1));

        // round robin, all requesters busy
        va = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = ADDR_W'(i + 1);
            rd[i] = DATA_W'(8'hA0 + i);
        end
        repeat (5) cycle("rr");
        va = '0;
        cycle("rr idle");

        // pointer fairness: after req 2, req 3 outranks req 0
        va = 4'b0100; ra[2] = 5'd7; rd[2] = 64'h77;
        cycle("fair r2");
        va = 4'b1001; ra[0] = 5'd8; rd[0] = 64'h88; ra[3] = 5'd9; rd[3] = 64'h99;
        cycle("fair r3");
        chk("fair r3 written", 64'(bus.wr_addr), 64'(9));
        va = 4'b0001;
        cycle("fair r0");
        chk("fair r0 written", 64'(bus.wr_addr), 64'(8));
        va = '0;
        cycle("fair idle");

        // XZR write accepted but suppressed; pointer moves past req 1
        va = 4'b0010; ra[1] = 5'd31; rd[1] = 64'hFF;
        cycle("xzr");
        chk("xzr wr_en", 64'(bus.wr_en), 64'(0));
        va = 4'hF;
        ra[2] = 5'd2; rd[2] = 64'hA2;
        apply();
        #1;
        chk("xzr ptr", 64'(bus.req_ready), 64'(4'b0100));
        cycle("xzr next");
        va = '0;
        cycle("xzr idle");

        // stall coinciding with a new request
        va = 4'b0001; ra[0] = 5'd3; rd[0] = 64'h33; st = 1'b1;
        cycle("stall req");
        cycle("stall req");
        st = 1'b0;
        cycle("stall drop");
        va = '0;
        cycle("stall idle");

        // duplicate addresses, serviced in grant order
        va = 4'b0110; ra[1] = 5'd12; rd[1] = 64'h1111; ra[2] = 5'd12; rd[2] = 64'h2222;
        cycle("dup a");
        va = va & ~dut.bus.req_ready;
        va = 4'b0110 & ~(4'b0010 << 0);
        va[m_ptr == 2 ? 1 : 2] = 1'b0;
        cycle("dup b");
        va = '0;
        cycle("dup idle");

        // reset in the middle of a RUN transfer
        va = 4'b0001; ra[0] = 5'd5; rd[0] = 64'h55;
        apply();
        #1;
        chk("midrst ready", 64'(bus.req_ready), 64'(4'b0001));
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("midrst held");
        va = '0;
        apply();
        reset_n = 1'b1;

        // second sweep with a 3-cycle stall at cnt 10
        for (int c = 0; c < 34; c++) begin
            st = (c >= 10 && c < 13);
            cycle("sweep2");
        end
        st = 1'b0;
        va = 4'b1000; ra[3] = 5'd20; rd[3] = 64'hDEAD;
        cycle("post rst");
        va = '0;
        cycle("post idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencing controller for the register-file write decoder. It shares the single write port (decoder `en`/`select`, write data) among `NREQ` requesters using round-robin arbitration. After every reset it first sweeps the register file to zero. Its registered outputs drive the 5-to-32 write-enable decoder tree (built from 2-to-4 decoders) and the register data inputs.

## Interface

Parameters:
- `NREQ`, default 4: number of write requesters, ≥2.
- `DATA_W`, default 64: register width.
- `ADDR_W`, default 5: register index width; 2**ADDR_W registers.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `wr_stall`, in, 1: register file busy. No grant and no clear step is taken while it is high.
- `req_valid`, in, NREQ: request i holds a pending write.
- `req_addr`, in, NREQ×ADDR_W: target register per requester.
- `req_data`, in, NREQ×DATA_W: write data per requester.
- `req_ready`, out, NREQ: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]` is high at a clock edge.
- `wr_en`, out, 1: registered decoder enable.
- `wr_addr`, out, ADDR_W: registered decoder select.
- `wr_data`, out, DATA_W: registered write data.
- `clear_done`, out, 1: high once the zeroing sweep has finished.

## Operation

- State machine with states CLEAR and RUN.
- Reset forces CLEAR, sets the clear counter `cnt` to 0 and the round-robin pointer `ptr` to 0.
- In CLEAR:
  - `req_ready` is all zero.
  - Each cycle with `wr_stall` low, the block registers `wr_en`=1, `wr_addr`=`cnt`, `wr_data`=0, then increments `cnt`.
  - When `cnt`=2**ADDR_W−2 is issued, the block moves to RUN. Register 2**ADDR_W−1 (XZR) is never written.
- In RUN:
  - The grant goes to the first `i` with `req_valid[i]`, searching circularly from `ptr`.
  - `req_ready[i]`=1 for that `i` only, and only when `wr_stall`=0. `req_ready` is combinational from `req_valid`, `ptr`, `wr_stall` and state.
  - On a transfer, the granted `req_addr`/`req_data` are registered onto `wr_addr`/`wr_data`, and `ptr` becomes (granted+1) mod NREQ.
  - `wr_en` is 1 on a transfer, except that a write to address 2**ADDR_W−1 is accepted (ready given, ptr advances) but produces `wr_en`=0.
  - With no transfer, `wr_en`=0 next cycle. `wr_addr`/`wr_data` hold their last values.
- Requests with `req_valid` low never receive ready. A stalled requester keeps its valid, address and data stable (requester obligation).
- Duplicate addresses from different requesters are serviced in grant order; the last writer wins.

## Timing

- Every output resets to 0 asynchronously (`wr_en`, `wr_addr`, `wr_data`, `req_ready`, `clear_done`). `clear_done` stays 0 until the last clear write has been registered.
- CLEAR with no stall:
  - Edges 1..31 after reset release present `wr_addr`=0..30 with `wr_en`=1.
  - `clear_done`=1 and state RUN from the 31st edge.
  - `req_ready` may first be asserted in the cycle after that edge.
- Stall during CLEAR pauses `cnt`. `wr_en`=0 for each stalled cycle, and the sweep resumes at the same address.
- RUN latency: a transfer at edge N puts `wr_en`/`wr_addr`/`wr_data` valid after edge N. There is 1 cycle of latency and one write per cycle at full throughput.
- `ptr` wraps from NREQ−1 to 0.
- Reset mid-sweep or mid-RUN aborts any write, clears all outputs immediately, and restarts the sweep from 0.
- `wr_stall` rising in the same cycle as a valid request means no ready and no transfer. The request is granted in the first cycle after stall drops.

## Structure

- Shared package `regfile_pkg`:
  - `ADDR_W`, `NREGS` = 2**ADDR_W, `ZERO_REG` = NREGS−1.
  - `typedef enum logic {CLEAR, RUN} wr_state_t`.
- One sub-module, `rr_arbiter`: a parameterized NREQ round-robin picker. Inputs are `req` and `ptr`; outputs are a one-hot `grant` and `any`. It is purely combinational.
- Top level holds the FSM, `cnt`, `ptr` and the output registers.

## Test plan

- **Reset sweep:** release `reset_n`, no stall. Expect `wr_en`=1 with `wr_addr` 0,1,…,30 on consecutive cycles, `wr_data`=0, `req_ready`=0 throughout, `clear_done`=1 after the 31st edge.
- **Stall in sweep:** assert `wr_stall` for 3 cycles while `cnt`=10. Expect `wr_en`=0 for 3 cycles, then `wr_addr`=10 resumes, with no address skipped or repeated.
- **Round robin:** all 4 requesters hold valid with addr i+1 and data 0xA0+i. Expect grants 0,1,2,3,0 on consecutive cycles and `wr_addr` 1,2,3,4,1 one cycle later.
- **Pointer fairness:** only req 2 is valid (1 grant). Then reqs 0 and 3 become valid together. Expect req 3 granted first, then req 0.
- **XZR write:** req 1 writes addr 31 with data 0xFF. Expect `req_ready[1]`=1, `wr_en`=0 next cycle, and `ptr` advanced to 2.
- **Mid-operation reset:** pull `reset_n` low during a RUN transfer. Expect all outputs 0 immediately, and the sweep to restart at `wr_addr`=0 after release.
